jstk_spi_responder: RTL and testbench

- SPI slave that emulates the PmodJSTK joystick, i.e. the responder end of the link driven by the joystick SPI master in the paddle path.
- Serves a second board acting as a remote controller, and serves as a synthesizable bus-functional model for sim benches.
- Snapshots X/Y/button inputs at chip-select assertion and shifts out the 5-byte JSTK report.
- Captures the master's LED command byte and exposes it.

---
 rtl/jstk_spi_responder.sv | 187 ++++++++++++++++++
 tb/tb_jstk_spi_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_responder.sv
// PmodJSTK-compatible SPI responder (mode 0, MSB first): serves the 5-byte X/Y/button report, captures the LED command.
// Optional malformed-frame reporting is enabled by defining JSTK_ERR_EN.

module jstk_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ff <= '0;
        else          ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

module jstk_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BYTES   = 5
) (
    input  logic       clk50M,
    input  logic       reset_n,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic       frame_done,
    output logic       frame_error,
    output logic [7:0] err_count
);
    localparam int NBITS = 8 * NUM_BYTES;
    localparam int CW    = $clog2(NBITS + 1);

    typedef enum logic [1:0] {ARMWAIT, IDLE, ACTIVE, OVERRUN} state_t;

    logic [2:0] raw_in, sync_out;
    logic       sck_s, cs_s, mosi_s, sck_q, cs_q;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;

    assign raw_in = {sck, cs, mosi};

    jstk_sync #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
        .clk     (clk50M),
        .reset_n (reset_n),
        .d       (raw_in),
        .q       (sync_out)
    );

    assign {sck_s, cs_s, mosi_s} = sync_out;

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            sck_q <= 1'b0;
            cs_q  <= 1'b0;
        end else begin
            sck_q <= sck_s;
            cs_q  <= cs_s;
        end
    end

    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign cs_rise  = cs_s & ~cs_q;
    assign cs_fall  = ~cs_s & cs_q;

    // Report byte idx; zero past the last byte so miso idles low after the final bit.
    function automatic logic [7:0] tx_byte(input int idx, input logic [9:0] x, input logic [9:0] y,
                                           input logic [2:0] b);
        logic [7:0] r;
        r = 8'h00;
        if (idx < NUM_BYTES) begin
            case (idx)
                0:       r = x[7:0];
                1:       r = {6'b0, x[9:8]};
                2:       r = y[7:0];
                3:       r = {6'b0, y[9:8]};
                4:       r = {5'b0, b};
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    state_t      state;
    logic [CW-1:0] bit_cnt, bit_cnt_nx;
    logic [7:0]  tx_sr, cmd;
    logic [6:0]  rx_sr;
    logic [9:0]  snap_x, snap_y;
    logic [2:0]  snap_b;

    assign bit_cnt_nx = bit_cnt + CW'(1);

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARMWAIT;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            cmd        <= '0;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_b     <= '0;
            miso       <= 1'b0;
            led        <= 2'b00;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ARMWAIT: begin
                    miso <= 1'b0;
                    if (cs_s) state <= IDLE;
                end
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        snap_x  <= x_pos;
                        snap_y  <= y_pos;
                        snap_b  <= buttons;
                        tx_sr   <= tx_byte(0, x_pos, y_pos, buttons);
                        miso    <= x_pos[7];
                        bit_cnt <= '0;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // cs rise has priority over any sck edge seen in the same clock
                    if (cs_rise) begin
                        miso  <= 1'b0;
                        state <= IDLE;
                        if (bit_cnt == CW'(NBITS)) begin
                            frame_done <= 1'b1;
                            if (cmd[7:2] == 6'b100000) led <= cmd[1:0];
                        end
                    end else if (sck_rise) begin
                        if (bit_cnt == CW'(NBITS)) begin
                            miso  <= 1'b0;
                            state <= OVERRUN;
                        end else begin
                            rx_sr   <= {rx_sr[5:0], mosi_s};
                            bit_cnt <= bit_cnt_nx;
                            if (bit_cnt == CW'(7)) cmd <= {rx_sr, mosi_s};
                            if (bit_cnt_nx[2:0] == 3'd0)
                                tx_sr <= tx_byte(int'(bit_cnt_nx[CW-1:3]), snap_x, snap_y, snap_b);
                            else
                                tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                    end else if (sck_fall) begin
                        miso <= tx_sr[7];
                    end
                end
                OVERRUN: begin
                    miso <= 1'b0;
                    if (cs_rise) state <= IDLE;
                end
                default: state <= ARMWAIT;
            endcase
        end
    end

`ifdef JSTK_ERR_EN
    logic bad_end;
    assign bad_end = cs_rise && ((state == ACTIVE && bit_cnt != CW'(NBITS)) || state == OVERRUN);

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            frame_error <= 1'b0;
            err_count   <= 8'h00;
        end else begin
            frame_error <= bad_end;
            if (bad_end && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
`else
    assign frame_error = 1'b0;
    assign err_count   = 8'h00;
`endif

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Scoreboarded bench for jstk_spi_responder: stimulus queues expected miso bytes and frame outcomes, monitors pop and compare.
`timescale 1ns/1ps

module tb_jstk_spi_responder;
    logic       clk50M = 1'b0;
    logic       reset_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [9:0] x_pos = 10'h2A5;
    logic [9:0] y_pos = 10'h13C;
    logic [2:0] buttons = 3'b101;
    logic [1:0] led;
    logic       frame_done, frame_error;
    logic [7:0] err_count;

    int n_vec = 0;
    int n_miss = 0;

    logic [7:0] exp_miso_q[$];
    logic [1:0] exp_done_q[$];
    logic [7:0] exp_err_q[$];

    jstk_spi_responder dut (
        .clk50M      (clk50M),
        .reset_n     (reset_n),
        .sck         (sck),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .buttons     (buttons),
        .led         (led),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .err_count   (err_count)
    );

    always #10 clk50M = ~clk50M;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_rep(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b);
        exp_miso_q.push_back(x[7:0]);
        exp_miso_q.push_back({6'b0, x[9:8]});
        exp_miso_q.push_back(y[7:0]);
        exp_miso_q.push_back({6'b0, y[9:8]});
        exp_miso_q.push_back({5'b0, b});
    endtask

    // SPI mode-0 master: mosi changes while sck is low, slave samples on rise.
    task automatic spi_xfer(input logic [7:0] cmd, input int nbits, input int half, input int chg_bit,
                            input bit do_fall, input bit do_rise);
        logic [39:0] tx;
        tx = {cmd, 32'h0};
        if (do_fall) begin
            @(negedge clk50M);
            cs = 1'b0;
        end
        repeat (half) @(negedge clk50M);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 40) ? tx[39 - i] : 1'b0;
            if (i == chg_bit) x_pos = 10'h3FF;
            repeat (half) @(negedge clk50M);
            sck = 1'b1;
            repeat (half) @(negedge clk50M);
            sck = 1'b0;
        end
        repeat (half) @(negedge clk50M);
        if (do_rise) begin
            cs = 1'b1;
            repeat (2 * half + 8) @(negedge clk50M);
        end
    endtask

    // miso byte monitor: samples where the master does, on sck rise
    initial begin
        int         mbit;
        logic [7:0] mrx;
        logic [7:0] e;
        mbit = 0;
        mrx  = 8'h00;
        forever begin
            @(posedge sck or negedge cs);
            if (sck) begin
                mrx = {mrx[6:0], miso};
                mbit++;
                if (mbit % 8 == 0 && exp_miso_q.size() > 0) begin
                    e = exp_miso_q.pop_front();
                    chk($sformatf("miso_byte%0d", mbit / 8 - 1), 32'(mrx), 32'(e));
                end
            end else begin
                mbit = 0;
            end
        end
    end

    // frame outcome monitor
    always @(negedge clk50M) begin
        if (reset_n) begin
            if (frame_done) begin
                if (exp_done_q.size() == 0) chk("frame_done_unexpected", 32'(frame_done), 32'h0);
                else chk("led_after_done", 32'(led), 32'(exp_done_q.pop_front()));
            end
            if (frame_error) begin
`ifdef JSTK_ERR_EN
                if (exp_err_q.size() == 0) chk("frame_error_unexpected", 32'(frame_error), 32'h0);
                else chk("err_count", 32'(err_count), 32'(exp_err_q.pop_front()));
`else
                chk("frame_error_tied", 32'(frame_error), 32'h0);
`endif
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk50M);
        chk("rst_miso", 32'(miso), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_frame_error", 32'(frame_error), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        reset_n = 1'b1;

        // frame already in progress at reset release: miso silent, ignored
        repeat (5) exp_miso_q.push_back(8'h00);
        spi_xfer(8'h83, 40, 25, -1, 1'b0, 1'b1);
        chk("armwait_led", 32'(led), 32'h0);

        push_rep(10'h2A5, 10'h13C, 3'b101);
        exp_done_q.push_back(2'b11);
        spi_xfer(8'h83, 40, 25, -1, 1'b1, 1'b1);

        push_rep(10'h2A5, 10'h13C, 3'b101);
        exp_done_q.push_back(2'b10);
        spi_xfer(8'h82, 40, 8, -1, 1'b1, 1'b1);

        push_rep(10'h2A5, 10'h13C, 3'b101);
        exp_done_q.push_back(2'b10);
        spi_xfer(8'h41, 40, 8, -1, 1'b1, 1'b1);

        // x changes mid-frame: current frame keeps snapshot, next frame sees new value
        x_pos = 10'h000;
        push_rep(10'h000, 10'h13C, 3'b101);
        exp_done_q.push_back(2'b10);
        spi_xfer(8'h00, 40, 8, 8, 1'b1, 1'b1);
        push_rep(10'h3FF, 10'h13C, 3'b101);
        exp_done_q.push_back(2'b10);
        spi_xfer(8'h00, 40, 8, -1, 1'b1, 1'b1);

        // short frame
`ifdef JSTK_ERR_EN
        exp_err_q.push_back(8'd1);
`endif
        spi_xfer(8'h81, 19, 8, -1, 1'b1, 1'b1);
        chk("short_led_hold", 32'(led), 32'h2);

        // over-length frame
        push_rep(10'h3FF, 10'h13C, 3'b101);
        spi_xfer(8'h81, 41, 8, -1, 1'b1, 1'b0);
        chk("overrun_miso", 32'(miso), 32'h0);
`ifdef JSTK_ERR_EN
        exp_err_q.push_back(8'd2);
`endif
        cs = 1'b1;
        repeat (24) @(negedge clk50M);
        chk("overrun_led_hold", 32'(led), 32'h2);

        // recovery after malformed frames
        push_rep(10'h3FF, 10'h13C, 3'b101);
        exp_done_q.push_back(2'b01);
        spi_xfer(8'h81, 40, 8, -1, 1'b1, 1'b1);

`ifdef JSTK_ERR_EN
        for (int k = 3; k <= 255; k++) begin
            exp_err_q.push_back(8'(k));
            spi_xfer(8'h81, 1, 4, -1, 1'b1, 1'b1);
        end
        exp_err_q.push_back(8'hFF);
        spi_xfer(8'h81, 1, 4, -1, 1'b1, 1'b1);
        chk("err_sat", 32'(err_count), 32'hFF);
`else
        repeat (3) spi_xfer(8'h81, 1, 4, -1, 1'b1, 1'b1);
        chk("err_count_tied", 32'(err_count), 32'h0);
`endif
        chk("led_final", 32'(led), 32'h1);

        repeat (20) @(negedge clk50M);
        chk("miso_q_drained", 32'(exp_miso_q.size()), 32'h0);
        chk("done_q_drained", 32'(exp_done_q.size()), 32'h0);
        chk("err_q_drained", 32'(exp_err_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
